// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern controller.
// Mode values match the 2-bit cfg_mode field.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } cfg_st_e;

endpackage

// File: rtl/tick_prescaler.sv
// Timebase divider: one-clk tick pulse every DIV clocks.
// Count runs 0..DIV-1; tick is high while count == DIV-1.
module tick_prescaler #(
  parameter int DIV = 27_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/PWM).
// Config writes are shadowed and applied on the next tick.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int TICK_DIV = 27_000,
  parameter int CNT_W    = 16,
  parameter int DUTY_W   = 8,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic [CH_NUM-1:0] led_out
);

  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_NUM);

  logic              w_tick;
  logic              w_acc;
  logic              w_ch_ok;
  logic              w_apply;
  cfg_st_e           r_st;
  cfg_st_e           w_st_nxt;
  logic [CH_W-1:0]   r_sh_ch;
  logic [1:0]        r_sh_mode;
  logic [CNT_W-1:0]  r_sh_per;
  logic [DUTY_W-1:0] r_sh_duty;
  logic [DUTY_W-1:0] r_pwm;
  logic [CH_NUM-1:0] w_led_nxt;
  logic [CH_NUM-1:0] r_led;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign cfg_ready = (r_st == ST_IDLE);
  assign w_acc     = cfg_valid && cfg_ready;
  assign w_ch_ok   = ({1'b0, cfg_ch} < CH_LIM);
  assign w_apply   = (r_st == ST_PEND) && w_tick;

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ST_IDLE: if (w_acc && w_ch_ok) w_st_nxt = ST_PEND;
      ST_PEND: if (w_tick) w_st_nxt = ST_IDLE;
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      r_sh_ch   <= '0;
      r_sh_mode <= MODE_OFF;
      r_sh_per  <= '0;
      r_sh_duty <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_acc && w_ch_ok) begin
        r_sh_ch   <= cfg_ch;
        r_sh_mode <= cfg_mode;
        r_sh_per  <= cfg_period;
        r_sh_duty <= cfg_duty;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_per;
    logic [CNT_W-1:0]  r_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_bst;
    logic              w_hit;
    logic              w_nxt;

    assign w_hit = w_apply && (r_sh_ch == CH_W'(i));

    // Apply restarts the blink phase lit; untouched channels keep counting.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mode <= MODE_OFF;
        r_per  <= '0;
        r_duty <= '0;
        r_cnt  <= '0;
        r_bst  <= 1'b0;
      end else if (w_hit) begin
        r_mode <= r_sh_mode;
        r_per  <= r_sh_per;
        r_duty <= r_sh_duty;
        r_cnt  <= '0;
        r_bst  <= 1'b1;
      end else if (w_tick) begin
        if (r_cnt == r_per) begin
          r_cnt <= '0;
          r_bst <= ~r_bst;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      w_nxt = 1'b0;
      unique case (r_mode)
        MODE_OFF:   w_nxt = 1'b0;
        MODE_ON:    w_nxt = 1'b1;
        MODE_BLINK: w_nxt = r_bst;
        MODE_PWM:   w_nxt = (r_pwm < r_duty);
        default:    w_nxt = 1'b0;
      endcase
    end

    assign w_led_nxt[i] = w_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led_out = r_led;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (4-channel and 3-channel instances).
// cyc counts edges since the last reset release; ticks apply on cyc%4==0.
module tb_led_pattern_ctrl;
  import led_pkg::*;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic [3:0] cfg_duty;
  logic [3:0] led_out;

  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_ch;
  logic [1:0] b_mode;
  logic [7:0] b_period;
  logic [3:0] b_duty;
  logic [2:0] b_led;

  int errs;
  int checks;
  int cyc;
  int n;

  led_pattern_ctrl #(
    .CH_NUM   (4),
    .TICK_DIV (4),
    .CNT_W    (8),
    .DUTY_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .led_out    (led_out)
  );

  led_pattern_ctrl #(
    .CH_NUM   (3),
    .TICK_DIV (4),
    .CNT_W    (8),
    .DUTY_W   (4)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (b_valid),
    .cfg_ready  (b_ready),
    .cfg_ch     (b_ch),
    .cfg_mode   (b_mode),
    .cfg_period (b_period),
    .cfg_duty   (b_duty),
    .led_out    (b_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [7:0] per, input logic [3:0] duty);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = duty;
    step();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0;
    b_valid = 1'b0; b_ch = '0; b_mode = '0;
    b_period = '0; b_duty = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led_out, 4'h0);
    check("rst_rdy", cfg_ready, 1'b1);
    rst = 1'b0;
    cyc = 0;

    // BLINK ch0 period=2: accept P1, apply P4, lit from cyc5
    wr(2'd0, MODE_BLINK, 8'd2, 4'd0);
    check("blk_rdy_lo", cfg_ready, 1'b0);
    go(4);
    check("blk_rdy_back", cfg_ready, 1'b1);
    check("blk_lat", led_out[0], 1'b0);
    go(5);
    check("blk_on", led_out[0], 1'b1);
    go(16);
    check("blk_hold", led_out[0], 1'b1);
    go(17);
    check("blk_off", led_out[0], 1'b0);
    check("blk_others", led_out[3:1], 3'b000);
    go(28);
    check("blk_off_hold", led_out[0], 1'b0);
    go(29);
    check("blk_on2", led_out[0], 1'b1);

    // PWM ch1 duty=5: apply P32; led at cyc c = ((c-1)%16) < duty
    wr(2'd1, MODE_PWM, 8'd0, 4'd5);
    go(33);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += int'(led_out[1]);
      step();
    end
    check("pwm5_cnt", n, 5);
    check("pwm5_ph_hi", led_out[1], 1'b1);
    go(54);
    check("pwm5_ph_lo", led_out[1], 1'b0);

    go(56);
    wr(2'd1, MODE_PWM, 8'd0, 4'd0);
    go(61);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += int'(led_out[1]);
      step();
    end
    check("pwm0_cnt", n, 0);

    wr(2'd1, MODE_PWM, 8'd0, 4'd15);
    go(81);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (cyc == 96) check("pwm15_gap", led_out[1], 1'b0);
      n += int'(led_out[1]);
      step();
    end
    check("pwm15_cnt", n, 15);

    // Back-to-back: ch2 ON accepted P98, ch3 held until ready returns
    cfg_valid = 1'b1;
    cfg_ch = 2'd2; cfg_mode = MODE_ON;
    cfg_period = '0; cfg_duty = '0;
    step();
    cfg_ch = 2'd3;
    check("hs_rdy_lo", cfg_ready, 1'b0);
    n = 0;
    while (!cfg_ready && n < 16) begin
      step();
      n++;
    end
    check("hs_rdy_cyc", cyc, 100);
    check("hs_ch2_lat", led_out[2], 1'b0);
    step();
    cfg_valid = 1'b0;
    check("hs_rdy_lo2", cfg_ready, 1'b0);
    check("hs_ch2_on", led_out[2], 1'b1);
    go(104);
    check("hs_rdy_back", cfg_ready, 1'b1);
    check("hs_ch3_lat", led_out[3], 1'b0);
    go(105);
    check("hs_ch3_on", led_out[3], 1'b1);

    // Accept on tick edge P108: apply must wait for P112
    go(107);
    wr(2'd2, MODE_OFF, 8'd0, 4'd0);
    check("tc_rdy_lo", cfg_ready, 1'b0);
    go(109);
    check("tc_not_now", led_out[2], 1'b1);
    go(111);
    check("tc_rdy_wait", cfg_ready, 1'b0);
    go(112);
    check("tc_rdy_back", cfg_ready, 1'b1);
    check("tc_hold", led_out[2], 1'b1);
    go(113);
    check("tc_applied", led_out[2], 1'b0);

    // Async reset mid-cycle with a write pending
    go(115);
    wr(2'd1, MODE_OFF, 8'd0, 4'd0);
    check("mr_pend", cfg_ready, 1'b0);
    check("mr_pre", led_out[3], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_led", led_out, 4'h0);
    check("mr_rdy", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    wr(2'd2, MODE_ON, 8'd0, 4'd0);
    check("mr_rdy_lo", cfg_ready, 1'b0);
    go(3);
    check("mr_pre_tick", cfg_ready, 1'b0);
    go(4);
    check("mr_tick4", cfg_ready, 1'b1);
    check("mr_led4", led_out, 4'h0);
    go(5);
    check("mr_led5", led_out, 4'b0100);

    // 3-channel instance: ch3 is dropped, ch2 still works
    b_valid = 1'b1;
    b_ch = 2'd3; b_mode = MODE_ON;
    step();
    b_valid = 1'b0;
    check("inv_rdy", b_ready, 1'b1);
    go(10);
    check("inv_led", b_led, 3'b000);
    check("inv_rdy2", b_ready, 1'b1);
    b_valid = 1'b1;
    b_ch = 2'd2; b_mode = MODE_ON;
    step();
    b_valid = 1'b0;
    check("b_rdy_lo", b_ready, 1'b0);
    go(13);
    check("b_led", b_led, 3'b100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
